// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and constants for the keypad column driver.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  typedef logic [3:0] key_code_t;

  localparam logic [3:0] COL_RESET = 4'b0001;
  localparam logic [3:0] COL_LAST  = 4'b1000;

endpackage

// File: rtl/column_ring.sv
// rtl/column_ring.sv - one-hot 4-bit column rotator with enable.
// Any non-one-hot value is pulled back to COL_RESET on the next edge regardless of enable.
module column_ring
  import keypad_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [3:0] col
);

  logic [3:0] col_q;
  logic [3:0] col_d;
  logic       one_hot;

  assign one_hot = (col_q != 4'b0000) && ((col_q & (col_q - 4'b0001)) == 4'b0000);

  always_comb begin
    col_d = col_q;
    if (!one_hot) begin
      col_d = COL_RESET;
    end else if (en) begin
      col_d = (col_q == COL_LAST) ? COL_RESET : {col_q[2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= COL_RESET;
    end else begin
      col_q <= col_d;
    end
  end

  assign col = col_q;

endmodule

// File: rtl/column_driver.sv
// rtl/column_driver.sv - keypad column scanner with press and release debouncing.
// Emits a one-cycle key_valid strobe per accepted press and key_held until release is debounced.
module column_driver
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       slow_clk,
  input  logic       rst,
  input  logic       key_pressed,
  input  logic [3:0] key_value,
  output logic [3:0] col_shift_reg,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] ACCEPT = CW'(DEBOUNCE_CYCLES - 1);

  state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  key_code_t cand_q, cand_d;
  key_code_t key_code_q, key_code_d;
  logic      key_valid_q, key_valid_d;
  logic      key_held_q, key_held_d;
  logic      ring_en;

  // Saturating increment; the cycle that triggers entry is the first stable one.
  assign cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    ring_en     = 1'b0;
    case (state_q)
      SCAN: begin
        if (key_pressed) begin
          cand_d  = key_value;
          cnt_d   = '0;
          state_d = DEBOUNCE;
        end else begin
          ring_en = 1'b1;
        end
      end
      DEBOUNCE: begin
        if (key_pressed && (key_value == cand_q)) begin
          if (cnt_inc >= ACCEPT) begin
            key_code_d  = cand_q;
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
            cnt_d       = '0;
            state_d     = HOLD;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          cnt_d   = '0;
          ring_en = 1'b1;
          state_d = SCAN;
        end
      end
      HOLD: begin
        if (!key_pressed) begin
          cnt_d   = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (key_pressed) begin
          cnt_d   = '0;
          state_d = HOLD;
        end else if (cnt_inc >= ACCEPT) begin
          key_held_d = 1'b0;
          cnt_d      = '0;
          state_d    = SCAN;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = SCAN;
      end
    endcase
  end

  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      state_q     <= SCAN;
      cnt_q       <= '0;
      cand_q      <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  column_ring u_ring (
    .clk (slow_clk),
    .rst (rst),
    .en  (ring_en),
    .col (col_shift_reg)
  );

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_column_driver.sv
// tb/tb_column_driver.sv - directed self-checking bench for column_driver.
module tb_column_driver;

  logic       slow_clk = 1'b0;
  logic       rst;
  logic       key_pressed;
  logic [3:0] key_value;
  logic [3:0] col_shift_reg;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  int n_checks = 0;
  int n_fail   = 0;

  column_driver #(.DEBOUNCE_CYCLES(4)) dut (
    .slow_clk      (slow_clk),
    .rst           (rst),
    .key_pressed   (key_pressed),
    .key_value     (key_value),
    .col_shift_reg (col_shift_reg),
    .key_code      (key_code),
    .key_valid     (key_valid),
    .key_held      (key_held)
  );

  always #5 slow_clk = ~slow_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then observe the outputs of the following cycle.
  task automatic step(input logic kp, input logic [3:0] kv);
    key_pressed = kp;
    key_value   = kv;
    @(posedge slow_clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] ring_exp [5];
    ring_exp[0] = 4'b0001; ring_exp[1] = 4'b0010; ring_exp[2] = 4'b0100;
    ring_exp[3] = 4'b1000; ring_exp[4] = 4'b0001;

    rst = 1'b1; key_pressed = 1'b0; key_value = 4'h0;
    repeat (2) @(posedge slow_clk);
    #1;
    check("rst_col",   col_shift_reg, 4'b0001);
    check("rst_code",  key_code,      4'h0);
    check("rst_valid", key_valid,     1'b0);
    check("rst_held",  key_held,      1'b0);
    rst = 1'b0;

    // Idle rotation
    check("idle_col0", col_shift_reg, ring_exp[0]);
    for (int i = 1; i < 5; i++) begin
      step(1'b0, 4'h0);
      check("idle_col", col_shift_reg, ring_exp[i]);
      check("idle_valid", key_valid, 1'b0);
    end

    // Stable 0101 press for 10 cycles, strobe during cycle 4
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 4'b0101);
      check("press_valid", key_valid, (i + 1 == 4) ? 1'b1 : 1'b0);
      check("press_held",  key_held,  (i + 1 >= 4) ? 1'b1 : 1'b0);
      check("press_col",   col_shift_reg, 4'b0001);
    end
    check("press_code", key_code, 4'b0101);

    // Release for 6 cycles starting at cycle 10
    for (int j = 0; j < 6; j++) begin
      step(1'b0, 4'b0000);
      check("rel_held",  key_held, (11 + j < 14) ? 1'b1 : 1'b0);
      check("rel_valid", key_valid, 1'b0);
      check("rel_col",   col_shift_reg,
            (11 + j <= 14) ? 4'b0001 : ((11 + j == 15) ? 4'b0010 : 4'b0100));
    end
    check("rel_code", key_code, 4'b0101);

    // Two-cycle bounce at column 0100
    step(1'b1, 4'b0110);
    check("bounce_col1", col_shift_reg, 4'b0100);
    step(1'b1, 4'b0110);
    check("bounce_col2", col_shift_reg, 4'b0100);
    step(1'b0, 4'b0110);
    check("bounce_col3",   col_shift_reg, 4'b1000);
    check("bounce_valid",  key_valid, 1'b0);
    check("bounce_held",   key_held,  1'b0);
    step(1'b0, 4'b0000);
    check("bounce_resume", col_shift_reg, 4'b0001);

    // key_value changes at DEBOUNCE cycle 2
    step(1'b1, 4'b1001);
    check("chg_valid1", key_valid, 1'b0);
    step(1'b1, 4'b1001);
    check("chg_valid2", key_valid, 1'b0);
    step(1'b1, 4'b0011);
    check("chg_valid3", key_valid, 1'b0);
    check("chg_col",    col_shift_reg, 4'b0010);
    check("chg_code",   key_code, 4'b0101);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'b0011);
      check("chg2_valid", key_valid, (i + 1 == 4) ? 1'b1 : 1'b0);
    end
    check("chg2_code", key_code, 4'b0011);
    check("chg2_held", key_held, 1'b1);

    // Release glitch in HOLD, with key_value noise that must be ignored
    begin
      logic [6:0] glitch;
      glitch = 7'b0000100;
      for (int g = 0; g < 7; g++) begin
        step(glitch[g], 4'b1111);
        check("glitch_held",  key_held, (g < 6) ? 1'b1 : 1'b0);
        check("glitch_valid", key_valid, 1'b0);
        check("glitch_col",   col_shift_reg, 4'b0010);
      end
    end
    check("glitch_code", key_code, 4'b0011);
    step(1'b0, 4'b0000);
    check("glitch_resume", col_shift_reg, 4'b0100);

    // Reset pulse while holding 1010
    for (int i = 0; i < 6; i++) step(1'b1, 4'b1010);
    check("hold_code", key_code, 4'b1010);
    check("hold_held", key_held, 1'b1);
    rst = 1'b1;
    #1;
    check("arst_code",  key_code,      4'h0);
    check("arst_held",  key_held,      1'b0);
    check("arst_col",   col_shift_reg, 4'b0001);
    check("arst_valid", key_valid,     1'b0);
    key_pressed = 1'b0;
    @(posedge slow_clk);
    #1;
    rst = 1'b0;
    step(1'b0, 4'b0000);
    check("arst_resume", col_shift_reg, 4'b0010);

    // Reset mid-DEBOUNCE produces no strobe
    step(1'b1, 4'b0111);
    step(1'b1, 4'b0111);
    rst = 1'b1;
    #1;
    check("dbrst_col", col_shift_reg, 4'b0001);
    @(posedge slow_clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 4'b0111);
      check("dbrst_valid", key_valid, 1'b0);
    end
    check("dbrst_code", key_code, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/column_driver.md
COLUMN_DRIVER -- requirements
Module: column_driver

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, range 2..255: consecutive stable cycles needed to accept a press or a release.
REQ-002 slow_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 key_pressed  input  1  row-scanner press flag, combinational from col_shift_reg and the rows; synchronous to slow_clk.
REQ-005 key_value  input  4  row-scanner decoded key for the currently driven column; synchronous to slow_clk.
REQ-006 col_shift_reg  output  4  registered one-hot column drive.
REQ-007 key_code  output  4  registered code of the last accepted key.
REQ-008 key_valid  output  1  registered single-cycle strobe on each accepted press.
REQ-009 key_held  output  1  registered; high while an accepted key has not yet been debounced as released.

Function
REQ-010 The FSM SHALL have four states: SCAN, DEBOUNCE, HOLD and RELEASE.
REQ-011 SCAN with key_pressed=0: col_shift_reg SHALL rotate one position per cycle, 0001->0010->0100->1000->0001.
REQ-012 SCAN with key_pressed=1: column held, key_value captured into candidate register, counter cleared, next state DEBOUNCE.
REQ-013 DEBOUNCE: column held; counter increments each cycle while key_pressed=1 and key_value equals the candidate.
REQ-014 DEBOUNCE abort: if key_pressed=0 or key_value differs from the candidate, next state SCAN with no strobe; the column advances one position on that same edge.
REQ-015 DEBOUNCE accept: once the counter shows DEBOUNCE_CYCLES-1 stable cycles, the next edge loads key_code from the candidate, pulses key_valid for exactly one cycle, sets key_held=1 and enters HOLD.
REQ-016 Latency: the first key_pressed=1 cycle is cycle 0; key_valid SHALL be high during cycle DEBOUNCE_CYCLES.
REQ-017 HOLD: column held; key_pressed=0 clears the counter and enters RELEASE; key_valid SHALL stay low.
REQ-018 RELEASE: counter increments while key_pressed=0; any key_pressed=1 cycle returns to HOLD with the counter cleared (glitch rejection).
REQ-019 Release accept: after DEBOUNCE_CYCLES consecutive key_pressed=0 cycles, key_held clears and the state returns to SCAN; rotation resumes on the following edge.
REQ-020 key_code SHALL hold its value until the next accepted press; it is never cleared by a release.
REQ-021 col_shift_reg SHALL be one-hot in every cycle; an illegal value SHALL be forced to 0001 on the next edge.
REQ-022 The counter SHALL be $clog2(DEBOUNCE_CYCLES+1) bits wide, saturate and never wrap.
REQ-023 A key_value change during HOLD or RELEASE SHALL be ignored; no new strobe occurs until the FSM returns to SCAN.

Reset
REQ-024 While rst=1, outputs SHALL be col_shift_reg=0001, key_code=0000, key_valid=0 and key_held=0; the state SHALL be SCAN, the counter 0 and the candidate 0000.
REQ-025 rst asserted mid-DEBOUNCE, mid-HOLD or mid-RELEASE SHALL abort immediately with no strobe; after deassertion scanning restarts at column 0001.

Structure
REQ-026 The shared package keypad_pkg SHALL hold the state enum, the column constants COL_RESET=4'b0001 and COL_LAST=4'b1000, and the 4-bit key-code type.
REQ-027 The one natural sub-module is column_ring, a one-hot 4-bit rotator with enable and illegal-state recovery; all other logic stays flat.

Verification
REQ-028 Idle rows (key_pressed=0) after reset -> col_shift_reg cycles 0001,0010,0100,1000,0001; key_valid stays 0.
REQ-029 Stable press key_value=0101 for 10 cycles, then release for 6 cycles, DEBOUNCE_CYCLES=4 -> key_valid pulses once at cycle 4, key_code=0101, key_held falls 4 cycles after release, scanning resumes.
REQ-030 Two-cycle bounce (key_pressed 1,1,0) -> no key_valid, FSM returns to SCAN, column advances one position.
REQ-031 Release glitch in HOLD (0,0,1,0,0,0,0) -> key_held stays 1 through the glitch, no second key_valid, SCAN only after 4 consecutive zeros.
REQ-032 key_value changes 1001->0011 at DEBOUNCE cycle 2 -> abort with no strobe; a later stable 0011 press is accepted with key_code=0011.
REQ-033 rst pulse during HOLD with key_code=1010 -> key_code=0000, key_held=0, col_shift_reg=0001 immediately.
